// File: rtl/hazard_control_unit.sv
// Pipeline hazard controller: load-use stall, taken-branch IF_ID flush and ID operand
// forwarding selects, with a small stall/flush FSM and saturating debug counters.
module hazard_control_unit #(
  parameter int unsigned REG_W = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             R,
  input  logic [REG_W-1:0] ID_Rn,
  input  logic [REG_W-1:0] ID_Rm,
  input  logic [REG_W-1:0] ID_Rd,
  input  logic             ID_use_Rn,
  input  logic             ID_use_Rm,
  input  logic             ID_use_Rd,
  input  logic [REG_W-1:0] EX_Rd,
  input  logic [REG_W-1:0] MEM_Rd,
  input  logic [REG_W-1:0] WB_Rd,
  input  logic             EX_RF_enable,
  input  logic             MEM_RF_enable,
  input  logic             WB_RF_enable,
  input  logic             EX_load_instr,
  input  logic             branch_taken,
  output logic             LE_PC,
  output logic             LE_IF_ID,
  output logic             S,
  output logic             IF_ID_flush,
  output logic [1:0]       fwd_A,
  output logic [1:0]       fwd_B,
  output logic [1:0]       fwd_C,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'b00,
    ST_STALL = 2'b01,
    ST_FLUSH = 2'b10
  } state_t;

  localparam logic [REG_W-1:0] PC_REG  = REG_W'(15);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_EX  = 2'b01;
  localparam logic [1:0] SEL_MEM = 2'b10;
  localparam logic [1:0] SEL_WB  = 2'b11;

  state_t           r_state;
  state_t           w_next_state;
  logic [CNT_W-1:0] r_stall_count;
  logic [CNT_W-1:0] r_flush_count;

  logic w_a_ex, w_a_mem, w_a_wb;
  logic w_b_ex, w_b_mem, w_b_wb;
  logic w_c_ex, w_c_mem, w_c_wb;
  logic w_lu;
  logic w_bf;
  logic [1:0] w_fwd_a, w_fwd_b, w_fwd_c;

  // R15 is the PC: it never produces a match, so it neither forwards nor stalls
  function automatic logic f_match(input logic             use_src,
                                   input logic [REG_W-1:0] src,
                                   input logic             rf_en,
                                   input logic [REG_W-1:0] dst);
    return use_src && rf_en && (dst == src) && (src != PC_REG);
  endfunction

  function automatic logic [1:0] f_sel(input logic m_ex, input logic m_mem, input logic m_wb);
    logic [1:0] sel;
    sel = SEL_RF;
    if (m_ex)       sel = SEL_EX;
    else if (m_mem) sel = SEL_MEM;
    else if (m_wb)  sel = SEL_WB;
    return sel;
  endfunction

  assign w_a_ex  = f_match(ID_use_Rn, ID_Rn, EX_RF_enable,  EX_Rd);
  assign w_a_mem = f_match(ID_use_Rn, ID_Rn, MEM_RF_enable, MEM_Rd);
  assign w_a_wb  = f_match(ID_use_Rn, ID_Rn, WB_RF_enable,  WB_Rd);
  assign w_b_ex  = f_match(ID_use_Rm, ID_Rm, EX_RF_enable,  EX_Rd);
  assign w_b_mem = f_match(ID_use_Rm, ID_Rm, MEM_RF_enable, MEM_Rd);
  assign w_b_wb  = f_match(ID_use_Rm, ID_Rm, WB_RF_enable,  WB_Rd);
  assign w_c_ex  = f_match(ID_use_Rd, ID_Rd, EX_RF_enable,  EX_Rd);
  assign w_c_mem = f_match(ID_use_Rd, ID_Rd, MEM_RF_enable, MEM_Rd);
  assign w_c_wb  = f_match(ID_use_Rd, ID_Rd, WB_RF_enable,  WB_Rd);

  assign w_fwd_a = f_sel(w_a_ex, w_a_mem, w_a_wb);
  assign w_fwd_b = f_sel(w_b_ex, w_b_mem, w_b_wb);
  assign w_fwd_c = f_sel(w_c_ex, w_c_mem, w_c_wb);

  // Stall wins over a simultaneous branch; FLUSH masks a stale branch_taken
  assign w_lu = EX_load_instr && (w_a_ex || w_b_ex || w_c_ex);
  assign w_bf = branch_taken && (r_state != ST_FLUSH) && !w_lu;

  always_ff @(posedge clk or negedge R) begin
    if (!R) r_state <= ST_RUN;
    else    r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = ST_RUN;
    LE_PC        = 1'b1;
    LE_IF_ID     = 1'b1;
    S            = 1'b0;
    IF_ID_flush  = 1'b0;
    fwd_A        = w_fwd_a;
    fwd_B        = w_fwd_b;
    fwd_C        = w_fwd_c;

    if (w_lu) begin
      w_next_state = ST_STALL;
      LE_PC        = 1'b0;
      LE_IF_ID     = 1'b0;
      S            = 1'b1;
    end else if (w_bf) begin
      w_next_state = ST_FLUSH;
      IF_ID_flush  = 1'b1;
    end

    // While reset is held the pipeline front end is frozen with a NOP injected
    if (!R) begin
      w_next_state = ST_RUN;
      LE_PC        = 1'b0;
      LE_IF_ID     = 1'b0;
      S            = 1'b1;
      IF_ID_flush  = 1'b0;
      fwd_A        = SEL_RF;
      fwd_B        = SEL_RF;
      fwd_C        = SEL_RF;
    end
  end

  always_ff @(posedge clk or negedge R) begin
    if (!R) begin
      r_stall_count <= '0;
      r_flush_count <= '0;
    end else begin
      if (w_lu && (r_stall_count != CNT_MAX)) r_stall_count <= r_stall_count + CNT_W'(1);
      if (w_bf && (r_flush_count != CNT_MAX)) r_flush_count <= r_flush_count + CNT_W'(1);
    end
  end

  assign state       = r_state;
  assign stall_count = r_stall_count;
  assign flush_count = r_flush_count;

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed bench for hazard_control_unit: combinational vector table plus
// hand-written reset, stall, flush, priority and saturation sequences.
module tb_hazard_control_unit;

  logic       clk;
  logic       R;
  logic [3:0] ID_Rn, ID_Rm, ID_Rd, EX_Rd, MEM_Rd, WB_Rd;
  logic       ID_use_Rn, ID_use_Rm, ID_use_Rd;
  logic       EX_RF_enable, MEM_RF_enable, WB_RF_enable;
  logic       EX_load_instr, branch_taken;

  logic        LE_PC, LE_IF_ID, S, IF_ID_flush;
  logic [1:0]  fwd_A, fwd_B, fwd_C, state;
  logic [15:0] stall_count, flush_count;

  logic        s_LE_PC, s_LE_IF_ID, s_S, s_IF_ID_flush;
  logic [1:0]  s_fwd_A, s_fwd_B, s_fwd_C, s_state;
  logic [2:0]  s_stall_count, s_flush_count;

  int n_pass;
  int n_total;

  hazard_control_unit #(.REG_W(4), .CNT_W(16)) dut (
    .clk(clk), .R(R),
    .ID_Rn(ID_Rn), .ID_Rm(ID_Rm), .ID_Rd(ID_Rd),
    .ID_use_Rn(ID_use_Rn), .ID_use_Rm(ID_use_Rm), .ID_use_Rd(ID_use_Rd),
    .EX_Rd(EX_Rd), .MEM_Rd(MEM_Rd), .WB_Rd(WB_Rd),
    .EX_RF_enable(EX_RF_enable), .MEM_RF_enable(MEM_RF_enable), .WB_RF_enable(WB_RF_enable),
    .EX_load_instr(EX_load_instr), .branch_taken(branch_taken),
    .LE_PC(LE_PC), .LE_IF_ID(LE_IF_ID), .S(S), .IF_ID_flush(IF_ID_flush),
    .fwd_A(fwd_A), .fwd_B(fwd_B), .fwd_C(fwd_C), .state(state),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  hazard_control_unit #(.REG_W(4), .CNT_W(3)) dut_s (
    .clk(clk), .R(R),
    .ID_Rn(ID_Rn), .ID_Rm(ID_Rm), .ID_Rd(ID_Rd),
    .ID_use_Rn(ID_use_Rn), .ID_use_Rm(ID_use_Rm), .ID_use_Rd(ID_use_Rd),
    .EX_Rd(EX_Rd), .MEM_Rd(MEM_Rd), .WB_Rd(WB_Rd),
    .EX_RF_enable(EX_RF_enable), .MEM_RF_enable(MEM_RF_enable), .WB_RF_enable(WB_RF_enable),
    .EX_load_instr(EX_load_instr), .branch_taken(branch_taken),
    .LE_PC(s_LE_PC), .LE_IF_ID(s_LE_IF_ID), .S(s_S), .IF_ID_flush(s_IF_ID_flush),
    .fwd_A(s_fwd_A), .fwd_B(s_fwd_B), .fwd_C(s_fwd_C), .state(s_state),
    .stall_count(s_stall_count), .flush_count(s_flush_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] rn;  logic urn;
    logic [3:0] rm;  logic urm;
    logic [3:0] rd;  logic urd;
    logic [3:0] exrd;  logic exen;
    logic [3:0] memrd; logic memen;
    logic [3:0] wbrd;  logic wben;
    logic       ld;
    logic       le_pc, le_ifid, s, fl;
    logic [1:0] fa, fb, fc;
  } vec_t;

  vec_t tbl [14];

  function automatic vec_t mk(input int rn, input int urn, input int rm, input int urm,
                              input int rd, input int urd, input int exrd, input int exen,
                              input int memrd, input int memen, input int wbrd, input int wben,
                              input int ld, input int le_pc, input int le_ifid, input int s,
                              input int fl, input int fa, input int fb, input int fc);
    vec_t v;
    v.rn = 4'(rn);       v.urn = 1'(urn);
    v.rm = 4'(rm);       v.urm = 1'(urm);
    v.rd = 4'(rd);       v.urd = 1'(urd);
    v.exrd = 4'(exrd);   v.exen = 1'(exen);
    v.memrd = 4'(memrd); v.memen = 1'(memen);
    v.wbrd = 4'(wbrd);   v.wben = 1'(wben);
    v.ld = 1'(ld);
    v.le_pc = 1'(le_pc); v.le_ifid = 1'(le_ifid); v.s = 1'(s); v.fl = 1'(fl);
    v.fa = 2'(fa); v.fb = 2'(fb); v.fc = 2'(fc);
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic clr_inputs();
    ID_Rn = '0; ID_Rm = '0; ID_Rd = '0;
    ID_use_Rn = 1'b0; ID_use_Rm = 1'b0; ID_use_Rd = 1'b0;
    EX_Rd = '0; MEM_Rd = '0; WB_Rd = '0;
    EX_RF_enable = 1'b0; MEM_RF_enable = 1'b0; WB_RF_enable = 1'b0;
    EX_load_instr = 1'b0; branch_taken = 1'b0;
  endtask

  task automatic apply_vec(input vec_t v);
    ID_Rn = v.rn; ID_use_Rn = v.urn;
    ID_Rm = v.rm; ID_use_Rm = v.urm;
    ID_Rd = v.rd; ID_use_Rd = v.urd;
    EX_Rd = v.exrd;   EX_RF_enable = v.exen;
    MEM_Rd = v.memrd; MEM_RF_enable = v.memen;
    WB_Rd = v.wbrd;   WB_RF_enable = v.wben;
    EX_load_instr = v.ld;
    branch_taken = 1'b0;
  endtask

  // Load in EX writing R5 while ID reads R5 through Rm
  task automatic set_lu();
    clr_inputs();
    ID_Rm = 4'd5; ID_use_Rm = 1'b1;
    EX_Rd = 4'd5; EX_RF_enable = 1'b1; EX_load_instr = 1'b1;
  endtask

  // Asynchronous reset pulse placed between clock edges
  task automatic pulse_reset();
    clr_inputs();
    R = 1'b0;
    #1;
    R = 1'b1;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;

    tbl[0]  = mk(0,0, 0,0, 0,0,  0,0, 0,0, 0,0, 0,  1,1,0,0, 0,0,0);
    tbl[1]  = mk(3,1, 0,0, 0,0,  3,1, 3,1, 3,1, 0,  1,1,0,0, 1,0,0);
    tbl[2]  = mk(3,1, 0,0, 0,0,  3,0, 3,1, 3,1, 0,  1,1,0,0, 2,0,0);
    tbl[3]  = mk(3,1, 0,0, 0,0,  3,0, 3,0, 3,1, 0,  1,1,0,0, 3,0,0);
    tbl[4]  = mk(3,1, 0,0, 0,0,  3,0, 3,0, 3,0, 0,  1,1,0,0, 0,0,0);
    tbl[5]  = mk(15,1, 0,0, 0,0, 15,1, 15,1, 15,1, 0, 1,1,0,0, 0,0,0);
    tbl[6]  = mk(15,1, 0,0, 0,0, 15,1, 15,1, 15,1, 1, 1,1,0,0, 0,0,0);
    tbl[7]  = mk(0,0, 5,1, 0,0,  5,1, 0,0, 0,0, 1,  0,0,1,0, 0,1,0);
    tbl[8]  = mk(0,0, 5,0, 0,0,  5,1, 0,0, 0,0, 1,  1,1,0,0, 0,0,0);
    tbl[9]  = mk(0,0, 0,0, 7,1,  7,1, 0,0, 0,0, 1,  0,0,1,0, 0,0,1);
    tbl[10] = mk(2,1, 4,1, 6,1,  2,1, 4,1, 6,1, 0,  1,1,0,0, 1,2,3);
    tbl[11] = mk(2,1, 4,1, 6,1,  2,0, 4,1, 6,1, 0,  1,1,0,0, 0,2,3);
    tbl[12] = mk(0,0, 5,1, 0,0,  5,0, 0,0, 0,0, 1,  1,1,0,0, 0,0,0);
    tbl[13] = mk(0,0, 0,0, 9,1,  1,1, 9,1, 9,1, 0,  1,1,0,0, 0,0,2);

    clr_inputs();
    R = 1'b0;
    #3;
    check("reset_le_pc", 32'(LE_PC), 32'd0);
    check("reset_le_ifid", 32'(LE_IF_ID), 32'd0);
    check("reset_s", 32'(S), 32'd1);
    check("reset_flush", 32'(IF_ID_flush), 32'd0);
    check("reset_state", 32'(state), 32'd0);
    check("reset_stall_cnt", 32'(stall_count), 32'd0);
    check("reset_flush_cnt", 32'(flush_count), 32'd0);
    #4;
    R = 1'b1;

    for (int i = 0; i < 14; i++) begin
      next_cycle();
      apply_vec(tbl[i]);
      #1;
      check($sformatf("vec%0d_le_pc", i), 32'(LE_PC), 32'(tbl[i].le_pc));
      check($sformatf("vec%0d_le_ifid", i), 32'(LE_IF_ID), 32'(tbl[i].le_ifid));
      check($sformatf("vec%0d_s", i), 32'(S), 32'(tbl[i].s));
      check($sformatf("vec%0d_flush", i), 32'(IF_ID_flush), 32'(tbl[i].fl));
      check($sformatf("vec%0d_fwd_a", i), 32'(fwd_A), 32'(tbl[i].fa));
      check($sformatf("vec%0d_fwd_b", i), 32'(fwd_B), 32'(tbl[i].fb));
      check($sformatf("vec%0d_fwd_c", i), 32'(fwd_C), 32'(tbl[i].fc));
    end

    // Load-use bubble then forwarding from MEM
    next_cycle();
    pulse_reset();
    set_lu();
    #1;
    check("lu_le_pc", 32'(LE_PC), 32'd0);
    check("lu_le_ifid", 32'(LE_IF_ID), 32'd0);
    check("lu_s", 32'(S), 32'd1);
    next_cycle();
    check("lu_state", 32'(state), 32'd1);
    check("lu_stall_cnt", 32'(stall_count), 32'd1);
    clr_inputs();
    ID_Rm = 4'd5; ID_use_Rm = 1'b1;
    MEM_Rd = 4'd5; MEM_RF_enable = 1'b1;
    #1;
    check("lu_next_fwd_b", 32'(fwd_B), 32'd2);
    check("lu_next_le_pc", 32'(LE_PC), 32'd1);
    check("lu_next_le_ifid", 32'(LE_IF_ID), 32'd1);
    check("lu_next_s", 32'(S), 32'd0);
    next_cycle();
    check("lu_back_run", 32'(state), 32'd0);
    check("lu_stall_cnt_hold", 32'(stall_count), 32'd1);

    // Taken branch flushes once even when held for two cycles
    pulse_reset();
    branch_taken = 1'b1;
    #1;
    check("bf_flush", 32'(IF_ID_flush), 32'd1);
    check("bf_le_pc", 32'(LE_PC), 32'd1);
    check("bf_s", 32'(S), 32'd0);
    next_cycle();
    check("bf_state", 32'(state), 32'd2);
    check("bf_flush_cnt", 32'(flush_count), 32'd1);
    check("bf_masked_flush", 32'(IF_ID_flush), 32'd0);
    check("bf_masked_le_pc", 32'(LE_PC), 32'd1);
    next_cycle();
    check("bf_after_state", 32'(state), 32'd0);
    check("bf_after_flush_cnt", 32'(flush_count), 32'd1);
    branch_taken = 1'b0;

    // Stall wins over a simultaneous branch; branch flushes the cycle after
    pulse_reset();
    set_lu();
    branch_taken = 1'b1;
    #1;
    check("sim_flush", 32'(IF_ID_flush), 32'd0);
    check("sim_s", 32'(S), 32'd1);
    next_cycle();
    check("sim_state", 32'(state), 32'd1);
    check("sim_flush_cnt", 32'(flush_count), 32'd0);
    check("sim_stall_cnt", 32'(stall_count), 32'd1);
    EX_load_instr = 1'b0;
    EX_RF_enable = 1'b0;
    #1;
    check("sim2_flush", 32'(IF_ID_flush), 32'd1);
    next_cycle();
    check("sim2_state", 32'(state), 32'd2);
    check("sim2_flush_cnt", 32'(flush_count), 32'd1);

    // Held load-use: 3-bit counter saturates, 16-bit counter keeps counting
    pulse_reset();
    set_lu();
    repeat (10) next_cycle();
    check("sat_small", 32'(s_stall_count), 32'd7);
    check("sat_wide", 32'(stall_count), 32'd10);
    check("sat_state", 32'(s_state), 32'd1);

    // Reset asserted mid-stall with lu still active
    #2;
    R = 1'b0;
    #1;
    check("midrst_le_pc", 32'(LE_PC), 32'd0);
    check("midrst_s", 32'(S), 32'd1);
    check("midrst_fwd_b", 32'(fwd_B), 32'd0);
    check("midrst_state", 32'(state), 32'd0);
    check("midrst_stall_cnt", 32'(stall_count), 32'd0);
    check("midrst_small_cnt", 32'(s_stall_count), 32'd0);
    clr_inputs();
    #1;
    R = 1'b1;
    #1;
    check("rel_le_pc", 32'(LE_PC), 32'd1);
    check("rel_s", 32'(S), 32'd0);
    next_cycle();
    check("rel_state", 32'(state), 32'd0);
    check("rel_le_ifid", 32'(LE_IF_ID), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
